// File: rtl/sc_collision_if.sv
// Bus between the collision scheduler and its environment: row/position inputs,
// shared-comparator operands and result, lives/score outputs and a state debug tap.
interface sc_collision_if #(
    parameter int DATAWIDTH   = 8,
    parameter int LIVES_WIDTH = 2
);
    // SC_COLLISION_tick_InHigh is a one-cycle strobe with no ready: the scheduler
    // accepts it only in WAIT, drops it in IDLE/OVER, and drops it with a sticky
    // overrun flag in CMP1/CMP2/UPDATE. Nothing is ever queued.
    logic                   SC_COLLISION_start_InHigh;
    logic                   SC_COLLISION_tick_InHigh;
    logic [DATAWIDTH-1:0]   SC_COLLISION_fila0_In;
    logic [DATAWIDTH-1:0]   SC_COLLISION_posjug1_In;
    logic [DATAWIDTH-1:0]   SC_COLLISION_posjug2_In;
    logic [DATAWIDTH-1:0]   SC_COLLISION_cmpfila_Out;
    logic [DATAWIDTH-1:0]   SC_COLLISION_cmppos_Out;
    logic                   SC_COLLISION_cmpnohit_In;
    logic                   SC_COLLISION_hit1_Out;
    logic                   SC_COLLISION_hit2_Out;
    logic [LIVES_WIDTH-1:0] SC_COLLISION_lives1_Out;
    logic [LIVES_WIDTH-1:0] SC_COLLISION_lives2_Out;
    logic                   SC_COLLISION_busy_Out;
    logic                   SC_COLLISION_overrun_Out;
    logic                   SC_COLLISION_gameover_Out;
    logic [1:0]             SC_COLLISION_winner_Out;
    logic [2:0]             SC_COLLISION_state_Out;

    modport master (
        output SC_COLLISION_start_InHigh, SC_COLLISION_tick_InHigh,
        output SC_COLLISION_fila0_In, SC_COLLISION_posjug1_In, SC_COLLISION_posjug2_In,
        output SC_COLLISION_cmpnohit_In,
        input  SC_COLLISION_cmpfila_Out, SC_COLLISION_cmppos_Out,
        input  SC_COLLISION_hit1_Out, SC_COLLISION_hit2_Out,
        input  SC_COLLISION_lives1_Out, SC_COLLISION_lives2_Out,
        input  SC_COLLISION_busy_Out, SC_COLLISION_overrun_Out,
        input  SC_COLLISION_gameover_Out, SC_COLLISION_winner_Out, SC_COLLISION_state_Out
    );

    modport slave (
        input  SC_COLLISION_start_InHigh, SC_COLLISION_tick_InHigh,
        input  SC_COLLISION_fila0_In, SC_COLLISION_posjug1_In, SC_COLLISION_posjug2_In,
        input  SC_COLLISION_cmpnohit_In,
        output SC_COLLISION_cmpfila_Out, SC_COLLISION_cmppos_Out,
        output SC_COLLISION_hit1_Out, SC_COLLISION_hit2_Out,
        output SC_COLLISION_lives1_Out, SC_COLLISION_lives2_Out,
        output SC_COLLISION_busy_Out, SC_COLLISION_overrun_Out,
        output SC_COLLISION_gameover_Out, SC_COLLISION_winner_Out, SC_COLLISION_state_Out
    );
endinterface

// File: rtl/sc_collision_scheduler.sv
// Two-player collision scheduler: snapshots row 0 and both positions on a tick and
// time-shares one external comparator over two cycles, then updates lives/winner.
module sc_collision_scheduler #(
    parameter int DATAWIDTH   = 8,
    parameter int LIVES_WIDTH = 2,
    parameter int LIVES_INIT  = 3
) (
    input logic             SC_COLLISION_CLOCK_50,
    input logic             SC_COLLISION_RESET_InHigh,
    sc_collision_if.slave   sc_if
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_CMP1   = 3'd2,
        S_CMP2   = 3'd3,
        S_UPDATE = 3'd4,
        S_OVER   = 3'd5
    } state_e;

    localparam logic [LIVES_WIDTH-1:0] LIVES_RELOAD = LIVES_WIDTH'(LIVES_INIT);

    state_e                 state_q, state_d;
    logic [DATAWIDTH-1:0]   fila_s_q, fila_s_d, pos1_s_q, pos1_s_d, pos2_s_q, pos2_s_d;
    logic                   h1_q, h1_d, h2_q, h2_d;
    logic                   hit1_q, hit1_d, hit2_q, hit2_d;
    logic [LIVES_WIDTH-1:0] lives1_q, lives1_d, lives2_q, lives2_d;
    logic [LIVES_WIDTH-1:0] lives1_dec, lives2_dec;
    logic                   overrun_q, overrun_d;
    logic [1:0]             winner_q, winner_d;

    always_ff @(posedge SC_COLLISION_CLOCK_50) begin
        if (SC_COLLISION_RESET_InHigh) state_q <= S_IDLE;
        else                           state_q <= state_d;
    end

    // Saturating decrement for whichever player the comparator flagged.
    always_comb begin
        lives1_dec = (h1_q && lives1_q != '0) ? lives1_q - 1'b1 : lives1_q;
        lives2_dec = (h2_q && lives2_q != '0) ? lives2_q - 1'b1 : lives2_q;
    end

    always_comb begin
        state_d   = state_q;
        fila_s_d  = fila_s_q;
        pos1_s_d  = pos1_s_q;
        pos2_s_d  = pos2_s_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
        hit1_d    = 1'b0;
        hit2_d    = 1'b0;
        lives1_d  = lives1_q;
        lives2_d  = lives2_q;
        overrun_d = overrun_q;
        winner_d  = winner_q;
        if (sc_if.SC_COLLISION_start_InHigh) begin
            state_d   = S_WAIT;
            lives1_d  = LIVES_RELOAD;
            lives2_d  = LIVES_RELOAD;
            overrun_d = 1'b0;
            winner_d  = 2'b00;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (sc_if.SC_COLLISION_tick_InHigh) begin
                        fila_s_d = sc_if.SC_COLLISION_fila0_In;
                        pos1_s_d = sc_if.SC_COLLISION_posjug1_In;
                        pos2_s_d = sc_if.SC_COLLISION_posjug2_In;
                        state_d  = S_CMP1;
                    end
                end
                S_CMP1: begin
                    h1_d    = ~sc_if.SC_COLLISION_cmpnohit_In;
                    state_d = S_CMP2;
                    if (sc_if.SC_COLLISION_tick_InHigh) overrun_d = 1'b1;
                end
                S_CMP2: begin
                    h2_d    = ~sc_if.SC_COLLISION_cmpnohit_In;
                    state_d = S_UPDATE;
                    if (sc_if.SC_COLLISION_tick_InHigh) overrun_d = 1'b1;
                end
                S_UPDATE: begin
                    hit1_d   = h1_q;
                    hit2_d   = h2_q;
                    lives1_d = lives1_dec;
                    lives2_d = lives2_dec;
                    if (sc_if.SC_COLLISION_tick_InHigh) overrun_d = 1'b1;
                    if (lives1_dec == '0 || lives2_dec == '0) begin
                        state_d  = S_OVER;
                        winner_d = {lives1_dec == '0, lives2_dec == '0} == 2'b11 ? 2'b11 :
                                   (lives1_dec == '0) ? 2'b10 : 2'b01;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_IDLE, S_OVER: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge SC_COLLISION_CLOCK_50) begin
        if (SC_COLLISION_RESET_InHigh) begin
            fila_s_q  <= '0;
            pos1_s_q  <= '0;
            pos2_s_q  <= '0;
            h1_q      <= 1'b0;
            h2_q      <= 1'b0;
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
            lives1_q  <= LIVES_RELOAD;
            lives2_q  <= LIVES_RELOAD;
            overrun_q <= 1'b0;
            winner_q  <= 2'b00;
        end else begin
            fila_s_q  <= fila_s_d;
            pos1_s_q  <= pos1_s_d;
            pos2_s_q  <= pos2_s_d;
            h1_q      <= h1_d;
            h2_q      <= h2_d;
            hit1_q    <= hit1_d;
            hit2_q    <= hit2_d;
            lives1_q  <= lives1_d;
            lives2_q  <= lives2_d;
            overrun_q <= overrun_d;
            winner_q  <= winner_d;
        end
    end

    // Operands are forced to zero outside the compare slots so an idle comparator reports no hit.
    always_comb begin
        sc_if.SC_COLLISION_cmpfila_Out  = '0;
        sc_if.SC_COLLISION_cmppos_Out   = '0;
        if (state_q == S_CMP1) begin
            sc_if.SC_COLLISION_cmpfila_Out = fila_s_q;
            sc_if.SC_COLLISION_cmppos_Out  = pos1_s_q;
        end else if (state_q == S_CMP2) begin
            sc_if.SC_COLLISION_cmpfila_Out = fila_s_q;
            sc_if.SC_COLLISION_cmppos_Out  = pos2_s_q;
        end
        sc_if.SC_COLLISION_busy_Out     = (state_q == S_CMP1) || (state_q == S_CMP2) ||
                                          (state_q == S_UPDATE);
        sc_if.SC_COLLISION_gameover_Out = (state_q == S_OVER);
        sc_if.SC_COLLISION_hit1_Out     = hit1_q;
        sc_if.SC_COLLISION_hit2_Out     = hit2_q;
        sc_if.SC_COLLISION_lives1_Out   = lives1_q;
        sc_if.SC_COLLISION_lives2_Out   = lives2_q;
        sc_if.SC_COLLISION_overrun_Out  = overrun_q;
        sc_if.SC_COLLISION_winner_Out   = winner_q;
        sc_if.SC_COLLISION_state_Out    = state_q;
    end
endmodule

// File: tb/tb_sc_collision_scheduler.sv
// Directed bench for sc_collision_scheduler: two instances (LIVES_INIT 3 and 1),
// each with a behavioural overlap comparator, checked against hand-computed values.
module tb_sc_collision_scheduler;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_CMP1 = 3'd2,
                         ST_CMP2 = 3'd3, ST_UPDATE = 3'd4, ST_OVER = 3'd5;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sc_collision_if #(.DATAWIDTH(8), .LIVES_WIDTH(2)) bus_a ();
  sc_collision_if #(.DATAWIDTH(8), .LIVES_WIDTH(2)) bus_b ();

  // Shared comparator model: no overlap between row and position means no hit.
  assign bus_a.SC_COLLISION_cmpnohit_In =
    ((bus_a.SC_COLLISION_cmpfila_Out & bus_a.SC_COLLISION_cmppos_Out) == 8'h00);
  assign bus_b.SC_COLLISION_cmpnohit_In =
    ((bus_b.SC_COLLISION_cmpfila_Out & bus_b.SC_COLLISION_cmppos_Out) == 8'h00);

  sc_collision_scheduler #(.DATAWIDTH(8), .LIVES_WIDTH(2), .LIVES_INIT(3)) dut_a (
    .SC_COLLISION_CLOCK_50     (clk),
    .SC_COLLISION_RESET_InHigh (rst),
    .sc_if                     (bus_a)
  );

  sc_collision_scheduler #(.DATAWIDTH(8), .LIVES_WIDTH(2), .LIVES_INIT(1)) dut_b (
    .SC_COLLISION_CLOCK_50     (clk),
    .SC_COLLISION_RESET_InHigh (rst),
    .sc_if                     (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    bus_a.SC_COLLISION_start_InHigh = 1'b1;
    step();
    bus_a.SC_COLLISION_start_InHigh = 1'b0;
  endtask

  // Tick instance A once and walk through CMP1/CMP2/UPDATE, capturing operands and busy cycles.
  task automatic run_tick_a(input logic [7:0] f, input logic [7:0] p1, input logic [7:0] p2,
                            output int busy_n, output logic [7:0] c1f, output logic [7:0] c1p,
                            output logic [7:0] c2f, output logic [7:0] c2p,
                            output logic [7:0] cuf);
    bus_a.SC_COLLISION_fila0_In   = f;
    bus_a.SC_COLLISION_posjug1_In = p1;
    bus_a.SC_COLLISION_posjug2_In = p2;
    bus_a.SC_COLLISION_tick_InHigh = 1'b1;
    step();
    bus_a.SC_COLLISION_tick_InHigh = 1'b0;
    busy_n = 0;
    if (bus_a.SC_COLLISION_busy_Out) busy_n++;
    c1f = bus_a.SC_COLLISION_cmpfila_Out;
    c1p = bus_a.SC_COLLISION_cmppos_Out;
    step();
    if (bus_a.SC_COLLISION_busy_Out) busy_n++;
    c2f = bus_a.SC_COLLISION_cmpfila_Out;
    c2p = bus_a.SC_COLLISION_cmppos_Out;
    step();
    if (bus_a.SC_COLLISION_busy_Out) busy_n++;
    cuf = bus_a.SC_COLLISION_cmpfila_Out | bus_a.SC_COLLISION_cmppos_Out;
    step();
    if (bus_a.SC_COLLISION_busy_Out) busy_n++;
  endtask

  initial begin
    int busy_n;
    logic [7:0] c1f, c1p, c2f, c2p, cuf;

    rst = 1'b1;
    bus_a.SC_COLLISION_start_InHigh = 1'b0;
    bus_a.SC_COLLISION_tick_InHigh  = 1'b0;
    bus_a.SC_COLLISION_fila0_In     = 8'h00;
    bus_a.SC_COLLISION_posjug1_In   = 8'h00;
    bus_a.SC_COLLISION_posjug2_In   = 8'h00;
    bus_b.SC_COLLISION_start_InHigh = 1'b0;
    bus_b.SC_COLLISION_tick_InHigh  = 1'b0;
    bus_b.SC_COLLISION_fila0_In     = 8'h00;
    bus_b.SC_COLLISION_posjug1_In   = 8'h00;
    bus_b.SC_COLLISION_posjug2_In   = 8'h00;
    step();
    step();

    // Reset state
    check("rst_state", bus_a.SC_COLLISION_state_Out, ST_IDLE);
    check("rst_lives1", bus_a.SC_COLLISION_lives1_Out, 3);
    check("rst_lives2", bus_a.SC_COLLISION_lives2_Out, 3);
    check("rst_flags", {bus_a.SC_COLLISION_hit1_Out, bus_a.SC_COLLISION_hit2_Out,
                        bus_a.SC_COLLISION_busy_Out, bus_a.SC_COLLISION_overrun_Out,
                        bus_a.SC_COLLISION_gameover_Out, bus_a.SC_COLLISION_winner_Out}, 0);
    check("rst_ops", {bus_a.SC_COLLISION_cmpfila_Out, bus_a.SC_COLLISION_cmppos_Out}, 0);
    check("rst_lives_b", {bus_b.SC_COLLISION_lives1_Out, bus_b.SC_COLLISION_lives2_Out}, 4'b0101);
    rst = 1'b0;

    // Tick while IDLE is ignored
    bus_a.SC_COLLISION_tick_InHigh = 1'b1;
    step();
    bus_a.SC_COLLISION_tick_InHigh = 1'b0;
    check("idle_tick", bus_a.SC_COLLISION_state_Out, ST_IDLE);

    // No collision
    start_a();
    check("start_wait", bus_a.SC_COLLISION_state_Out, ST_WAIT);
    run_tick_a(8'h01, 8'h02, 8'h04, busy_n, c1f, c1p, c2f, c2p, cuf);
    check("nohit_busy", busy_n, 3);
    check("nohit_hits", {bus_a.SC_COLLISION_hit1_Out, bus_a.SC_COLLISION_hit2_Out}, 2'b00);
    check("nohit_lives", {bus_a.SC_COLLISION_lives1_Out, bus_a.SC_COLLISION_lives2_Out}, 4'hF);
    check("nohit_ovr", bus_a.SC_COLLISION_overrun_Out, 1'b0);
    check("nohit_state", bus_a.SC_COLLISION_state_Out, ST_WAIT);

    // Player 2 collision
    start_a();
    run_tick_a(8'h04, 8'h01, 8'h04, busy_n, c1f, c1p, c2f, c2p, cuf);
    check("p2_cmp1_ops", {c1f, c1p}, 16'h0401);
    check("p2_cmp2_ops", {c2f, c2p}, 16'h0404);
    check("p2_upd_ops", cuf, 8'h00);
    check("p2_hits", {bus_a.SC_COLLISION_hit1_Out, bus_a.SC_COLLISION_hit2_Out}, 2'b01);
    check("p2_lives", {bus_a.SC_COLLISION_lives1_Out, bus_a.SC_COLLISION_lives2_Out}, 4'b1110);
    check("p2_wait_ops", {bus_a.SC_COLLISION_cmpfila_Out, bus_a.SC_COLLISION_cmppos_Out}, 0);

    // Two more back-to-back collisions at 4-cycle spacing drain player 2
    run_tick_a(8'h04, 8'h01, 8'h04, busy_n, c1f, c1p, c2f, c2p, cuf);
    check("p2b_hit_no_loss", {bus_a.SC_COLLISION_hit2_Out, bus_a.SC_COLLISION_lives2_Out}, 3'b101);
    check("p2b_ovr", bus_a.SC_COLLISION_overrun_Out, 1'b0);
    run_tick_a(8'h04, 8'h01, 8'h04, busy_n, c1f, c1p, c2f, c2p, cuf);
    check("over_lives", {bus_a.SC_COLLISION_lives1_Out, bus_a.SC_COLLISION_lives2_Out}, 4'b1100);
    check("over_flag", bus_a.SC_COLLISION_gameover_Out, 1'b1);
    check("over_winner", bus_a.SC_COLLISION_winner_Out, 2'b01);
    check("over_state", bus_a.SC_COLLISION_state_Out, ST_OVER);
    step();
    check("over_hit_clear", bus_a.SC_COLLISION_hit2_Out, 1'b0);
    run_tick_a(8'h04, 8'h04, 8'h04, busy_n, c1f, c1p, c2f, c2p, cuf);
    check("over_tick_busy", busy_n, 0);
    check("over_tick_lives", {bus_a.SC_COLLISION_lives1_Out, bus_a.SC_COLLISION_lives2_Out}, 4'b1100);
    check("over_tick_hold", {bus_a.SC_COLLISION_state_Out, bus_a.SC_COLLISION_winner_Out,
                             bus_a.SC_COLLISION_hit1_Out, bus_a.SC_COLLISION_overrun_Out},
          {ST_OVER, 2'b01, 1'b0, 1'b0});

    // LIVES_INIT=1 instance: both hit in one tick gives a draw
    bus_b.SC_COLLISION_start_InHigh = 1'b1;
    step();
    bus_b.SC_COLLISION_start_InHigh = 1'b0;
    bus_b.SC_COLLISION_fila0_In   = 8'h03;
    bus_b.SC_COLLISION_posjug1_In = 8'h01;
    bus_b.SC_COLLISION_posjug2_In = 8'h02;
    bus_b.SC_COLLISION_tick_InHigh = 1'b1;
    step();
    bus_b.SC_COLLISION_tick_InHigh = 1'b0;
    step();
    step();
    step();
    check("draw_hits", {bus_b.SC_COLLISION_hit1_Out, bus_b.SC_COLLISION_hit2_Out}, 2'b11);
    check("draw_lives", {bus_b.SC_COLLISION_lives1_Out, bus_b.SC_COLLISION_lives2_Out}, 4'b0000);
    check("draw_result", {bus_b.SC_COLLISION_gameover_Out, bus_b.SC_COLLISION_winner_Out}, 3'b111);
    bus_b.SC_COLLISION_start_InHigh = 1'b1;
    step();
    bus_b.SC_COLLISION_start_InHigh = 1'b0;
    check("restart_lives", {bus_b.SC_COLLISION_lives1_Out, bus_b.SC_COLLISION_lives2_Out}, 4'b0101);
    check("restart_result", {bus_b.SC_COLLISION_gameover_Out, bus_b.SC_COLLISION_winner_Out}, 3'b000);
    check("restart_state", bus_b.SC_COLLISION_state_Out, ST_WAIT);

    // Overrun and snapshot: inputs zeroed after E0, second tick during CMP2
    start_a();
    check("restart_a", {bus_a.SC_COLLISION_lives1_Out, bus_a.SC_COLLISION_lives2_Out,
                        bus_a.SC_COLLISION_gameover_Out}, 5'b11110);
    bus_a.SC_COLLISION_fila0_In   = 8'h04;
    bus_a.SC_COLLISION_posjug1_In = 8'h01;
    bus_a.SC_COLLISION_posjug2_In = 8'h04;
    bus_a.SC_COLLISION_tick_InHigh = 1'b1;
    step();
    bus_a.SC_COLLISION_tick_InHigh = 1'b0;
    bus_a.SC_COLLISION_fila0_In   = 8'h00;
    bus_a.SC_COLLISION_posjug2_In = 8'h00;
    step();
    bus_a.SC_COLLISION_tick_InHigh = 1'b1;
    step();
    bus_a.SC_COLLISION_tick_InHigh = 1'b0;
    check("ovr_set", bus_a.SC_COLLISION_overrun_Out, 1'b1);
    step();
    check("snap_hit2", bus_a.SC_COLLISION_hit2_Out, 1'b1);
    check("snap_lives", {bus_a.SC_COLLISION_lives1_Out, bus_a.SC_COLLISION_lives2_Out}, 4'b1110);
    step();
    step();
    step();
    step();
    check("ovr_single_dec", {bus_a.SC_COLLISION_lives2_Out, bus_a.SC_COLLISION_state_Out},
          {2'd2, ST_WAIT});
    check("ovr_sticky", bus_a.SC_COLLISION_overrun_Out, 1'b1);

    // Reset during CMP2 aborts the evaluation
    start_a();
    check("start_clears_ovr", bus_a.SC_COLLISION_overrun_Out, 1'b0);
    bus_a.SC_COLLISION_fila0_In   = 8'h04;
    bus_a.SC_COLLISION_posjug2_In = 8'h04;
    bus_a.SC_COLLISION_tick_InHigh = 1'b1;
    step();
    bus_a.SC_COLLISION_tick_InHigh = 1'b0;
    step();
    check("in_cmp2", bus_a.SC_COLLISION_state_Out, ST_CMP2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state", bus_a.SC_COLLISION_state_Out, ST_IDLE);
    check("abort_lives", {bus_a.SC_COLLISION_lives1_Out, bus_a.SC_COLLISION_lives2_Out}, 4'hF);
    step();
    check("abort_nohit", {bus_a.SC_COLLISION_hit1_Out, bus_a.SC_COLLISION_hit2_Out,
                          bus_a.SC_COLLISION_lives2_Out}, 4'b0011);

    // Start and tick together: WAIT with no evaluation
    bus_a.SC_COLLISION_start_InHigh = 1'b1;
    bus_a.SC_COLLISION_tick_InHigh  = 1'b1;
    step();
    bus_a.SC_COLLISION_start_InHigh = 1'b0;
    bus_a.SC_COLLISION_tick_InHigh  = 1'b0;
    check("st_tick_state", bus_a.SC_COLLISION_state_Out, ST_WAIT);
    check("st_tick_busy", bus_a.SC_COLLISION_busy_Out, 1'b0);
    step();
    step();
    step();
    check("st_tick_final", {bus_a.SC_COLLISION_state_Out, bus_a.SC_COLLISION_lives2_Out,
                            bus_a.SC_COLLISION_hit2_Out}, {ST_WAIT, 2'd3, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
